mem_boot_loader: RTL and testbench
==================================

// Module: mem_boot_loader
// PURPOSE
//  Boot-time sequencer for the core's instruction RAM (InstCatch) and byte-lane data RAM (DataCatch).
//  Accepts a stream of 32-bit words and writes them to a flat word space: inst RAM first, then data RAM.
//  Reads the image back and checks a mod-2^32 checksum. Holds the core in stall until a good load completes.
//  External RAM-port muxes select this block's ports while core_hold=1, and the core ports otherwise.
// PARAMETERS
//  IM_AW          10  inst RAM word-address width (depth 2^IM_AW)
//  DM_AW          10  data RAM word-address width (depth 2^DM_AW); IM_AW >= DM_AW
//  HOLD_AT_RESET  1   reset value of core_hold
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      load request; sampled only in IDLE
//  word_cnt   in   IM_AW+2  words to load; sampled on start; >2^IM_AW+2^DM_AW clamps to that total
//  exp_sum    in   32     expected checksum; sampled on start
//  s_valid    in   1      stream word valid
//  s_ready    out  1      stream word accepted when s_valid&s_ready
//  s_data     in   32     stream word
//  im_we      out  1      inst RAM write enable
//  im_addr    out  IM_AW  inst RAM word address
//  im_wdata   out  32     inst RAM write data
//  im_rdata   in   32     inst RAM read data, 1-cycle latency after im_addr
//  dm_we      out  4      data RAM byte-lane write enables [3]=bits31:24 .. [0]=bits7:0
//  dm_addr    out  DM_AW  data RAM word address
//  dm_wdata   out  32     data RAM write data
//  dm_rdata   in   32     data RAM read data, 1-cycle latency
//  core_hold  out  1      1 = core stalled and RAM ports owned by loader
//  busy       out  1      LOAD or VERIFY active
//  done       out  1      one-cycle pulse on successful completion
//  err        out  1      checksum mismatch; sticky until next accepted start
// BEHAVIOUR
//  - All outputs are registered, except s_ready = (state==LOAD).
//  - Reset values: state=IDLE; we=0; addr=0; wdata=0; busy=0; done=0; err=0; core_hold=HOLD_AT_RESET.
//  - Reset mid-operation aborts immediately with the reset values above. RAM contents written so far are kept.
//  - FSM states: IDLE, LOAD, VERIFY, CHECK, DONE, ERR.
//  - IDLE: on start, latch cnt/exp_sum, set idx=0 and sum=0, core_hold=1, err=0.
//    - cnt==0: go to DONE.
//    - otherwise: go to LOAD with busy=1.
//  - LOAD: each handshake at cycle T drives the write at T+1 (we for 1 cycle), then idx++.
//    - idx < 2^IM_AW: im_we=1, im_addr=idx.
//    - idx >= 2^IM_AW: dm_we=4'hF, dm_addr=idx-2^IM_AW.
//    - Gaps in s_valid are allowed; no writes occur in gap cycles.
//    - Handshake of word cnt-1: go to VERIFY.
//  - VERIFY: one read address per cycle, ridx 0..cnt-1, same address split as LOAD.
//    - The first read is driven the cycle after the final write strobe.
//    - Returned data (next cycle, from im_rdata or dm_rdata per the registered bank select) is added to sum, mod 2^32.
//    - After the last word has accumulated: go to CHECK.
//  - CHECK (1 cycle): sum==exp_sum goes to DONE, otherwise to ERR.
//  - DONE (1 cycle): done=1, busy=0, core_hold=0, then IDLE.
//  - ERR: err=1, busy=0, core_hold stays 1, then IDLE; err holds until the next start.
//  - start outside IDLE is ignored; s_valid outside LOAD is ignored.
//  - A new start after DONE re-asserts core_hold on the next cycle.
// TESTING
//  1. cnt=4, words 0x00000013 x4, exp_sum=0x4C
//     -> im_we at addr 0..3; done pulse after CHECK; core_hold 1->0; err=0.
//  2. cnt=1026
//     -> word 1023: im_addr=1023; word 1024: dm_we=4'hF, dm_addr=0; word 1025: dm_addr=1; checksum passes.
//  3. cnt=2, exp_sum off by 1
//     -> err=1, core_hold stays 1, no done; next start with correct sum -> err clears, done pulses.
//  4. Words 0xFFFFFFFF,0x00000002 with random s_valid gaps, exp_sum=0x1
//     -> pass (wrap); no we strobe in gap cycles.
//  5. rst low after 3 of 8 words
//     -> all outputs at reset values within the same cycle; restart writes from idx 0.
//  6. cnt=0 -> done on the 2nd cycle after start with no we; cnt=4095 -> clamps to 2048 and the last write is dm_addr=1023.

Source files
------------

// File: rtl/mem_boot_loader.sv
// Boot-time loader for the instruction and data RAMs.
// Streams words into a flat word space (inst RAM first, then data RAM), reads the
// image back, compares a mod-2^32 checksum and holds the core in stall until a
// good image is in place.
module mem_boot_loader #(
  parameter int IM_AW         = 10,
  parameter int DM_AW         = 10,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IM_AW+1:0]    word_cnt,
  input  logic [31:0]         exp_sum,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         s_data,
  output logic                im_we,
  output logic [IM_AW-1:0]    im_addr,
  output logic [31:0]         im_wdata,
  input  logic [31:0]         im_rdata,
  output logic [3:0]          dm_we,
  output logic [DM_AW-1:0]    dm_addr,
  output logic [31:0]         dm_wdata,
  input  logic [31:0]         dm_rdata,
  output logic                core_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = IM_AW + 2;
  localparam logic [CW-1:0] IM_WORDS = CW'(2 ** IM_AW);
  localparam logic [CW-1:0] TOTAL    = CW'((2 ** IM_AW) + (2 ** DM_AW));

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       exp_q, exp_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [31:0]       sum_q, sum_d;
  logic              im_we_q, im_we_d;
  logic [IM_AW-1:0]  im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [3:0]        dm_we_q, dm_we_d;
  logic [DM_AW-1:0]  dm_addr_q, dm_addr_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  // Read-issue stage (address on the RAM bus) and read-return stage (data back)
  logic              issue_q, issue_d;
  logic              issue_dm_q, issue_dm_d;
  logic              issue_last_q, issue_last_d;
  logic              rvld_q, rvld_d;
  logic              rdm_q, rdm_d;
  logic              rlast_q, rlast_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_hold_q, core_hold_d;

  logic [CW-1:0]     cnt_in;
  logic              sel_dm;
  logic              last_idx;

  assign cnt_in   = (word_cnt > TOTAL) ? TOTAL : word_cnt;
  assign sel_dm   = (idx_q >= IM_WORDS);
  assign last_idx = (idx_q == (cnt_q - CW'(1)));

  assign s_ready   = (state_q == LOAD);
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign core_hold = core_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // State and registered-output flops; reset aborts any load in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      exp_q        <= '0;
      idx_q        <= '0;
      sum_q        <= '0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      dm_we_q      <= '0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      issue_q      <= 1'b0;
      issue_dm_q   <= 1'b0;
      issue_last_q <= 1'b0;
      rvld_q       <= 1'b0;
      rdm_q        <= 1'b0;
      rlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_hold_q  <= HOLD_AT_RESET;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      issue_q      <= issue_d;
      issue_dm_q   <= issue_dm_d;
      issue_last_q <= issue_last_d;
      rvld_q       <= rvld_d;
      rdm_q        <= rdm_d;
      rlast_q      <= rlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_hold_q  <= core_hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cnt_in == '0) ? DONE : LOAD;
      LOAD:    if (s_valid && last_idx) state_d = VERIFY;
      VERIFY:  if (rvld_q && rlast_q) state_d = CHECK;
      CHECK:   state_d = (sum_q == exp_q) ? DONE : ERR;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic: strobes default low, everything else holds
  always_comb begin
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    dm_we_d      = 4'h0;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    issue_d      = 1'b0;
    issue_dm_d   = issue_dm_q;
    issue_last_d = 1'b0;
    rvld_d       = issue_q;
    rdm_d        = issue_dm_q;
    rlast_d      = issue_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    core_hold_d  = core_hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d       = cnt_in;
          exp_d       = exp_sum;
          idx_d       = '0;
          sum_d       = '0;
          core_hold_d = 1'b1;
          err_d       = 1'b0;
          busy_d      = (cnt_in != '0);
        end
      end
      LOAD: begin
        if (s_valid) begin
          if (!sel_dm) begin
            im_we_d    = 1'b1;
            im_addr_d  = idx_q[IM_AW-1:0];
            im_wdata_d = s_data;
          end else begin
            dm_we_d    = 4'hF;
            dm_addr_d  = DM_AW'(idx_q - IM_WORDS);
            dm_wdata_d = s_data;
          end
          // idx is reused as the read index once the last word is written
          idx_d = last_idx ? '0 : idx_q + CW'(1);
        end
      end
      VERIFY: begin
        if (idx_q < cnt_q) begin
          issue_d      = 1'b1;
          issue_dm_d   = sel_dm;
          issue_last_d = last_idx;
          if (!sel_dm) im_addr_d = idx_q[IM_AW-1:0];
          else         dm_addr_d = DM_AW'(idx_q - IM_WORDS);
          idx_d = idx_q + CW'(1);
        end
        if (rvld_q) sum_d = sum_q + (rdm_q ? dm_rdata : im_rdata);
      end
      DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        core_hold_d = 1'b0;
      end
      ERR: begin
        err_d  = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: RAM models, randomized stream driver and a
// scoreboard monitor for RAM writes and load outcomes.
module tb_mem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] word_cnt;
  logic [31:0] exp_sum;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;
  logic [3:0]  dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  mem_boot_loader #(.IM_AW(10), .DM_AW(10), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .rst(rst_n), .start(start), .word_cnt(word_cnt), .exp_sum(exp_sum),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_rdata(im_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  // Synchronous RAMs with one cycle of read latency
  logic [31:0] im_mem [1024];
  logic [31:0] dm_mem [1024];
  always @(posedge clk) begin
    if (im_we) im_mem[im_addr] <= im_wdata;
    im_rdata <= im_mem[im_addr];
    for (int b = 0; b < 4; b++)
      if (dm_we[b]) dm_mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
    dm_rdata <= dm_mem[dm_addr];
  end

  typedef struct {
    bit          dm;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  bit          res_q[$];
  logic [31:0] pat[$];
  int          checks = 0;
  int          failures = 0;
  int          completions = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must follow a handshake and match the queued write;
  // every done pulse / err rise must match the queued outcome
  wr_t  e;
  bit   r;
  bit   hs_prev;
  logic err_prev;
  logic strobe;
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev  = 1'b0;
      err_prev = 1'b0;
    end else begin
      strobe = im_we || (dm_we != 4'h0);
      if (strobe || hs_prev) chk("we_follows_handshake", strobe, hs_prev);
      if (im_we) begin
        chk("im_write_queued", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("im_write_bank", 0, e.dm);
          chk("im_addr", im_addr, e.addr);
          chk("im_wdata", im_wdata, e.data);
        end
      end
      if (dm_we != 4'h0) begin
        chk("dm_we_lanes", dm_we, 4'hF);
        chk("dm_write_queued", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("dm_write_bank", 1, e.dm);
          chk("dm_addr", dm_addr, e.addr);
          chk("dm_wdata", dm_wdata, e.data);
        end
      end
      if (done) begin
        chk("done_result_queued", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          chk("done_expected_pass", 1, r);
        end
        chk("done_core_hold", core_hold, 0);
        chk("done_busy", busy, 0);
        completions++;
      end
      if (err && !err_prev) begin
        chk("err_result_queued", res_q.size() != 0, 1);
        if (res_q.size() != 0) begin
          r = res_q.pop_front();
          chk("err_expected_fail", 0, r);
        end
        chk("err_core_hold", core_hold, 1);
        chk("err_busy", busy, 0);
        completions++;
      end
      err_prev = err;
      hs_prev  = s_valid && s_ready;
    end
  end

  // Reference: flat word index -> RAM bank/address
  function automatic wr_t map_word(input int idx, input logic [31:0] d);
    wr_t w;
    w.dm   = (idx >= 1024);
    w.addr = (idx >= 1024) ? idx - 1024 : idx;
    w.data = d;
    return w;
  endfunction

  function automatic logic [31:0] sum_pat(input int n);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < n; i++) s = s + pat[i];
    return s;
  endfunction

  task automatic fill_rand(input int n);
    pat.delete();
    for (int i = 0; i < n; i++) pat.push_back($urandom());
  endtask

  task automatic send_word(input logic [31:0] d, input int gap_pct, inout int idx, output bit ok);
    bit hs;
    for (int g = 0; g < 4; g++) begin
      if ($urandom_range(99) >= gap_pct) break;
      s_valid = 1'b0;
      s_data  = $urandom();
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      hs = s_ready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    if (ok) begin
      wq.push_back(map_word(idx, d));
      idx++;
    end
  endtask

  task automatic issue_start(input int cnt, input logic [31:0] exp, input bit pass);
    res_q.push_back(pass);
    word_cnt = 12'(cnt);
    exp_sum  = exp;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Full load: start, stream the (clamped) word count from pat, await outcome
  task automatic run_load(input int cnt, input logic [31:0] exp, input bit pass, input int gap_pct);
    int n;
    int idx;
    int c0;
    bit ok;
    n   = (cnt > 2048) ? 2048 : cnt;
    idx = 0;
    c0  = completions;
    issue_start(cnt, exp, pass);
    chk("hold_after_start", core_hold, 1);
    chk("err_clear_on_start", err, 0);
    chk("busy_after_start", busy, n != 0);
    if (n == 0) begin
      chk("done_low_1st_cycle", done, 0);
      @(posedge clk); #1;
      chk("done_2nd_cycle", done, 1);
    end
    for (int i = 0; i < n; i++) begin
      send_word(pat[i], gap_pct, idx, ok);
      if (!ok) begin
        chk("stream_handshake", ok, 1);
        break;
      end
    end
    for (int t = 0; t < 3 * n + 50; t++) begin
      if (completions != c0) break;
      @(posedge clk); #1;
    end
    chk("completion_seen", completions != c0, 1);
    chk("all_writes_seen", wq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_im_we"}, im_we, 0);
    chk({tag, "_dm_we"}, dm_we, 0);
    chk({tag, "_im_addr"}, im_addr, 0);
    chk({tag, "_dm_addr"}, dm_addr, 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_dm_wdata"}, dm_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_core_hold"}, core_hold, 1);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit ok;
    bit pass;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    word_cnt = '0;
    exp_sum  = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four identical words, checksum 4*0x13
    pat.delete();
    repeat (4) pat.push_back(32'h0000_0013);
    run_load(4, 32'h0000_004C, 1'b1, 0);
    chk("t1_core_hold_released", core_hold, 0);
    chk("t1_err", err, 0);

    // Crosses from inst RAM into data RAM
    fill_rand(1026);
    run_load(1026, sum_pat(1026), 1'b1, 20);

    // Bad checksum: err sticky, core stays held, then a good retry
    fill_rand(2);
    run_load(2, sum_pat(2) + 32'h1, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_err_sticky", err, 1);
    chk("t3_hold_kept", core_hold, 1);
    chk("t3_no_done", done, 0);
    run_load(2, sum_pat(2), 1'b1, 0);
    chk("t3_err_cleared", err, 0);

    // Checksum wrap with random gaps
    pat.delete();
    pat.push_back(32'hFFFF_FFFF);
    pat.push_back(32'h0000_0002);
    run_load(2, 32'h0000_0001, 1'b1, 50);

    // Reset after 3 of 8 words, then a complete reload from index 0
    fill_rand(8);
    idx = 0;
    issue_start(8, sum_pat(8), 1'b1);
    for (int i = 0; i < 3; i++) send_word(pat[i], 0, idx, ok);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload_reset");
    wq.delete();
    res_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(8, sum_pat(8), 1'b1, 30);

    // Zero-length load, then an over-long count clamped to both RAMs
    run_load(0, 32'h0, 1'b1, 0);
    fill_rand(2048);
    run_load(4095, sum_pat(2048), 1'b1, 0);

    // Random loads with random outcomes
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(40, 1);
      pass = $urandom_range(1);
      fill_rand(n);
      run_load(n, pass ? sum_pat(n) : sum_pat(n) ^ 32'h0000_0100, pass, 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
